// File: rtl/hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// Valid/ready: mem_req_m is the request valid and mem_ready the ready. An
// access completes in any cycle where both are high. The requester holds
// mem_req_m until that cycle, or until the controller gives up waiting.
interface hazard_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic [4:0]           rs1_d;
  logic [4:0]           rs2_d;
  logic [4:0]           rs1_e;
  logic [4:0]           rs2_e;
  logic [4:0]           rd_e;
  logic [1:0]           result_src_e;
  logic                 pc_src_e;
  logic [4:0]           rd_m;
  logic                 reg_write_m;
  logic                 mem_req_m;
  logic                 mem_ready;
  logic [4:0]           rd_w;
  logic                 reg_write_w;
  logic [1:0]           forward_a_e;
  logic [1:0]           forward_b_e;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 stall_m;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_w;
  logic                 mem_err;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic                 fsm_wait;   // debug: memory FSM is in WAIT

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
           rd_m, reg_write_m, mem_req_m, mem_ready, rd_w, reg_write_w,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err, stall_cnt, fsm_wait
  );

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e, pc_src_e,
           rd_m, reg_write_m, mem_req_m, mem_ready, rd_w, reg_write_w,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err, stall_cnt, fsm_wait
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// It produces the E-stage forwarding selects, the load-use stall, the branch
// flush and the data-memory wait stall with timeout. It also keeps a sticky
// timeout error flag and a saturating count of PC-stall cycles.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);
  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t               state_q;
  logic [TW-1:0]        timer_q;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic load_stall, mem_wait;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  // M stage beats W stage; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       rw_m,
                                          input logic [4:0] rd_w,
                                          input logic       rw_w);
    if (rw_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (rw_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign hz.forward_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
  assign hz.forward_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);

  assign load_stall = (hz.result_src_e == 2'b01) && (hz.rd_e != 5'd0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // The stall shows up in the request cycle itself. It drops in the last
  // timer cycle, so a timed-out access stalls for exactly MEM_TIMEOUT cycles.
  assign mem_wait = ((state_q == ST_IDLE) && hz.mem_req_m && !hz.mem_ready) ||
                    ((state_q == ST_WAIT) && !hz.mem_ready && (timer_q != T_LAST));

  // Stall/flush priority: memory wait, then branch, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.stall_f   = stall_f;
  assign hz.stall_d   = stall_d;
  assign hz.stall_e   = stall_e;
  assign hz.stall_m   = stall_m;
  assign hz.flush_d   = flush_d;
  assign hz.flush_e   = flush_e;
  assign hz.flush_w   = flush_w;
  assign hz.mem_err   = err_q;
  assign hz.stall_cnt = cnt_q;
  assign hz.fsm_wait  = (state_q == ST_WAIT);

  // Memory wait FSM with timer and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hz.mem_req_m && !hz.mem_ready) begin
            state_q <= ST_WAIT;
            timer_q <= '0;
          end
        end
        ST_WAIT: begin
          if (hz.mem_ready) begin
            state_q <= ST_IDLE;
          end else if (timer_q == T_LAST) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_f && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Register the stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule
